sd_wb_byte_bridge: RTL and testbench

- Wishbone classic 32-bit slave that converts each word access into a sequence of single-byte accesses on the byte-wide register-file port of the SD controller register block.
- Sits directly upstream of the register block: it drives the block's write enable, 7-bit byte address and write data, and it samples the block's combinational read data.
- Lanes are accessed in descending order (byte 3 first, byte 0 last). A word write to the argument or ISR register therefore finishes with its byte-0 write, so the side-effect strobe (cmd_start / int reset) fires only after the upper bytes are already stored.

---
 rtl/sd_wb_byte_bridge_if.sv | 27 ++
 rtl/sd_wb_byte_bridge.sv | 106 ++++++++++
 tb/tb_sd_wb_byte_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_wb_byte_bridge_if.sv
// rtl/sd_wb_byte_bridge_if.sv - Wishbone word port and byte register-file port of the byte bridge
interface sd_wb_byte_bridge_if #(
    parameter int ADDR_W = 7
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [3:0]        wb_sel_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic [7:0]        reg_rdata;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, reg_rdata,
        output wb_dat_o, wb_ack_o, reg_we, reg_addr, reg_wdata
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, reg_rdata,
        input  wb_dat_o, wb_ack_o, reg_we, reg_addr, reg_wdata
    );
endinterface

// File: rtl/sd_wb_byte_bridge.sv
// rtl/sd_wb_byte_bridge.sv - Wishbone 32-bit slave split into descending single-byte register accesses
module sd_wb_byte_bridge #(
    parameter int ADDR_W     = 7,
    parameter bit SKIP_UNSEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    sd_wb_byte_bridge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LANE, ACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:2] adr_l;
    logic              we_l;
    logic [3:0]        sel_l;
    logic [31:0]       dat_l;
    logic [1:0]        lane;
    logic [31:0]       dat_o_r;

    logic              start;
    logic [3:0]        lower_sel;
    logic              last_lane;
    logic [1:0]        nxt_lane;

    function automatic logic [1:0] hi_lane(input logic [3:0] s);
        logic [1:0] t;
        t = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) t = 2'(i);
        end
        return t;
    endfunction

    assign start     = bus.wb_cyc_i & bus.wb_stb_i;
    assign lower_sel = sel_l & ((4'b0001 << lane) - 4'b0001);
    assign last_lane = (lane == 2'd0) || (SKIP_UNSEL && (lower_sel == 4'b0000));
    assign nxt_lane  = SKIP_UNSEL ? hi_lane(lower_sel) : lane - 2'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (SKIP_UNSEL && (bus.wb_sel_i == 4'b0000)) ? ACK : LANE;
                end
            end
            LANE: begin
                // Dropping cyc mid-walk abandons the access without an ack.
                if (!bus.wb_cyc_i) begin
                    state_nxt = IDLE;
                end else if (last_lane) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            adr_l   <= '0;
            we_l    <= 1'b0;
            sel_l   <= 4'b0000;
            dat_l   <= 32'd0;
            lane    <= 2'd0;
            dat_o_r <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        adr_l <= bus.wb_adr_i[ADDR_W-1:2];
                        we_l  <= bus.wb_we_i;
                        sel_l <= bus.wb_sel_i;
                        dat_l <= bus.wb_dat_i;
                        lane  <= SKIP_UNSEL ? hi_lane(bus.wb_sel_i) : 2'd3;
                        if (!bus.wb_we_i) dat_o_r <= 32'd0;
                    end
                end
                LANE: begin
                    if (!we_l && sel_l[lane]) dat_o_r[{lane, 3'b000} +: 8] <= bus.reg_rdata;
                    if (!last_lane) lane <= nxt_lane;
                end
                default: ;
            endcase
        end
    end

    // reg_addr/reg_wdata follow the latches, so they hold their last value outside LANE.
    always_comb begin
        bus.reg_we    = (state == LANE) & we_l & sel_l[lane];
        bus.reg_addr  = {adr_l, lane};
        bus.reg_wdata = dat_l[{lane, 3'b000} +: 8];
        bus.wb_ack_o  = (state == ACK);
        bus.wb_dat_o  = dat_o_r;
    end
endmodule

// File: tb/tb_sd_wb_byte_bridge.sv
// tb/tb_sd_wb_byte_bridge.sv - Self-checking bench for sd_wb_byte_bridge, both SKIP_UNSEL settings
module tb_sd_wb_byte_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          checks   = 0;
    int          failures = 0;

    logic        we_d;
    logic [6:0]  adr_d;
    logic [3:0]  sel_d;
    logic [31:0] dat_d;
    logic [1:0]  cyc_v;
    logic [1:0]  stb_v;
    logic        init_req;
    bit          chained = 1'b0;

    logic [7:0]  seed  [128];
    logic [7:0]  rmem0 [128];
    logic [7:0]  rmem1 [128];
    logic [7:0]  emem  [2][128];
    logic [31:0] last_rd [2];

    sd_wb_byte_bridge_if #(.ADDR_W(7)) bus0 ();
    sd_wb_byte_bridge_if #(.ADDR_W(7)) bus1 ();

    sd_wb_byte_bridge #(.ADDR_W(7), .SKIP_UNSEL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    sd_wb_byte_bridge #(.ADDR_W(7), .SKIP_UNSEL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus0.wb_cyc_i = cyc_v[0];
    assign bus0.wb_stb_i = stb_v[0];
    assign bus0.wb_we_i  = we_d;
    assign bus0.wb_adr_i = adr_d;
    assign bus0.wb_sel_i = sel_d;
    assign bus0.wb_dat_i = dat_d;
    assign bus1.wb_cyc_i = cyc_v[1];
    assign bus1.wb_stb_i = stb_v[1];
    assign bus1.wb_we_i  = we_d;
    assign bus1.wb_adr_i = adr_d;
    assign bus1.wb_sel_i = sel_d;
    assign bus1.wb_dat_i = dat_d;

    // Register block stand-in: combinational read, byte write on the clock edge.
    assign bus0.reg_rdata = rmem0[bus0.reg_addr];
    assign bus1.reg_rdata = rmem1[bus1.reg_addr];

    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 128; a++) begin
                rmem0[a] <= seed[a];
                rmem1[a] <= seed[a];
            end
        end else begin
            if (bus0.reg_we) rmem0[bus0.reg_addr] <= bus0.reg_wdata;
            if (bus1.reg_we) rmem1[bus1.reg_addr] <= bus1.reg_wdata;
        end
    end

    function automatic logic o_ack(input int w);
        return (w == 1) ? bus1.wb_ack_o : bus0.wb_ack_o;
    endfunction
    function automatic logic o_we(input int w);
        return (w == 1) ? bus1.reg_we : bus0.reg_we;
    endfunction
    function automatic logic [6:0] o_addr(input int w);
        return (w == 1) ? bus1.reg_addr : bus0.reg_addr;
    endfunction
    function automatic logic [7:0] o_wd(input int w);
        return (w == 1) ? bus1.reg_wdata : bus0.reg_wdata;
    endfunction
    function automatic logic [31:0] o_dat(input int w);
        return (w == 1) ? bus1.wb_dat_o : bus0.wb_dat_o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone access on instance w; abort_at>0 drops cyc during that cycle.
    task automatic txn(input int w, input logic we, input logic [6:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input int abort_at, input bit keep, input string tag);
        int          lanes[$];
        logic [31:0] exp_wr[$];
        logic [31:0] obs_wr[$];
        logic [31:0] exp_ad[$];
        logic [31:0] obs_ad[$];
        logic [31:0] rd_exp;
        logic [31:0] rd_obs;
        logic [6:0]  a;
        int          vis;
        int          exp_ack;
        int          ack_n;

        for (int l = 3; l >= 0; l--) begin
            if (w == 0 || sel[l]) lanes.push_back(l);
        end
        vis     = lanes.size();
        if (abort_at > 0 && abort_at < vis) vis = abort_at;
        exp_ack = (abort_at > 0) ? 0 : lanes.size() + 1;

        rd_exp = 32'd0;
        for (int l = 0; l < 4; l++) begin
            a = {adr[6:2], 2'(l)};
            if (sel[l]) rd_exp[8*l +: 8] = emem[w][a];
        end
        for (int i = 0; i < vis; i++) begin
            a = {adr[6:2], 2'(lanes[i])};
            exp_ad.push_back({25'd0, a});
            if (we && sel[lanes[i]]) begin
                exp_wr.push_back({8'd0, 8'(i + 1), 1'b0, a, dat[8*lanes[i] +: 8]});
                emem[w][a] = dat[8*lanes[i] +: 8];
            end
        end

        if (!chained) @(negedge clk);
        we_d     = we;
        adr_d    = adr;
        sel_d    = sel;
        dat_d    = dat;
        cyc_v[w] = 1'b1;
        stb_v[w] = 1'b1;
        if (chained) @(posedge clk);
        chained = 1'b0;
        @(posedge clk);

        ack_n  = 0;
        rd_obs = 32'd0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (o_ack(w)) begin
                ack_n  = n;
                rd_obs = o_dat(w);
                break;
            end
            if (o_we(w)) obs_wr.push_back({8'd0, 8'(n), 1'b0, o_addr(w), o_wd(w)});
            if (n <= vis) obs_ad.push_back({25'd0, o_addr(w)});
            we_d  = 1'($urandom);
            adr_d = 7'($urandom);
            sel_d = 4'($urandom);
            dat_d = $urandom;
            if (abort_at == n) begin
                cyc_v[w] = 1'b0;
                stb_v[w] = 1'b0;
            end
        end

        chk({tag, "_ack_cycle"}, 32'(ack_n), 32'(exp_ack));
        chk({tag, "_wr_count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            chk({tag, "_wr_event"}, obs_wr[i], exp_wr[i]);
        for (int i = 0; i < exp_ad.size() && i < obs_ad.size(); i++)
            chk({tag, "_lane_addr"}, obs_ad[i], exp_ad[i]);

        if (ack_n != 0) begin
            if (!we) last_rd[w] = rd_exp;
            chk({tag, "_dat_o"}, rd_obs, last_rd[w]);
        end

        if (ack_n != 0 && keep) begin
            chained = 1'b1;
        end else begin
            cyc_v[w] = 1'b0;
            stb_v[w] = 1'b0;
            if (ack_n != 0) begin
                @(negedge clk);
                chk({tag, "_ack_single"}, 32'(o_ack(w)), 32'd0);
            end
        end
    endtask

    task automatic chk_reset_outputs(input int w, input string tag);
        chk({tag, "_ack"},   32'(o_ack(w)),  32'd0);
        chk({tag, "_we"},    32'(o_we(w)),   32'd0);
        chk({tag, "_addr"},  32'(o_addr(w)), 32'd0);
        chk({tag, "_wdata"}, 32'(o_wd(w)),   32'd0);
        chk({tag, "_dat_o"}, o_dat(w),       32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          mism;

        rst      = 1'b0;
        init_req = 1'b1;
        cyc_v    = 2'b00;
        stb_v    = 2'b00;
        we_d     = 1'b0;
        adr_d    = 7'd0;
        sel_d    = 4'd0;
        dat_d    = 32'd0;
        for (int a = 0; a < 128; a++) seed[a] = 8'($urandom);
        seed[4] = 8'h11;
        seed[5] = 8'h22;
        for (int a = 0; a < 128; a++) begin
            emem[0][a] = seed[a];
            emem[1][a] = seed[a];
        end
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (3) @(posedge clk);
        init_req = 1'b0;
        @(negedge clk);
        chk_reset_outputs(0, "reset0");
        chk_reset_outputs(1, "reset1");
        rst = 1'b1;

        txn(0, 1'b1, 7'h00, 4'hF, 32'hDEADBEEF, 0, 1'b0, "word_wr");
        txn(0, 1'b0, 7'h05, 4'h3, 32'h0, 0, 1'b0, "part_rd");
        txn(1, 1'b1, 7'h20, 4'h1, 32'h000000A5, 0, 1'b0, "skip_wr");
        txn(1, 1'b0, 7'h44, 4'h0, 32'h0, 0, 1'b0, "skip_rd0");
        txn(1, 1'b0, 7'h20, 4'h5, 32'h0, 0, 1'b0, "skip_rd5");

        txn(0, 1'b1, 7'h40, 4'hF, $urandom, 1, 1'b0, "abort");
        txn(0, 1'b0, 7'h40, 4'hF, 32'h0, 0, 1'b0, "post_abort");

        // Reset during cycle 2 of a write: lanes 3 and 2 reach the register block.
        d = $urandom;
        @(negedge clk);
        we_d = 1'b1; adr_d = 7'h50; sel_d = 4'hF; dat_d = d;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs(0, "midrst");
        cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        rst = 1'b1;
        emem[0][7'h53] = d[31:24];
        emem[0][7'h52] = d[23:16];
        emem[1][7'h00] = emem[1][7'h00];
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(negedge clk);
        txn(0, 1'b0, 7'h50, 4'hF, 32'h0, 0, 1'b0, "post_rst");
        txn(1, 1'b0, 7'h50, 4'hF, 32'h0, 0, 1'b0, "post_rst1");

        txn(0, 1'b1, 7'h30, 4'hF, $urandom, 0, 1'b1, "b2b_a");
        txn(0, 1'b1, 7'h34, 4'hF, $urandom, 0, 1'b0, "b2b_b");
        txn(1, 1'b1, 7'h60, 4'hA, $urandom, 0, 1'b1, "b2b_c");
        txn(1, 1'b0, 7'h60, 4'hE, 32'h0, 0, 1'b0, "b2b_d");

        for (int i = 0; i < 30; i++) begin
            txn(int'($urandom_range(0, 1)), 1'($urandom), 7'($urandom), 4'($urandom),
                $urandom, 0, 1'b0, "rand");
        end

        @(negedge clk);
        mism = 0;
        for (int a = 0; a < 128; a++) begin
            if (rmem0[a] !== emem[0][a]) mism++;
            if (rmem1[a] !== emem[1][a]) mism++;
        end
        chk("mem_final", 32'(mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
